// File: rtl/sha_ctrl_pkg.sv
// Shared types and constants for the SHA-256 round sequencer.
package sha_ctrl_pkg;

    localparam int ADDR_WTH   = 6;
    localparam int NUM_ROUNDS = 64;
    localparam int MSG_WORDS  = 16;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ROUND,
        FINAL,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/sha_round_ctrl_if.sv
// Control bundle between the hash FSM, the round datapath and sha_round_ctrl.
// i_abort is present only when SHA_RC_CTRL_ABORT_EN is defined.
interface sha_round_ctrl_if #(
    parameter int ADDR_WTH = sha_ctrl_pkg::ADDR_WTH
);
    logic                i_start;
    logic                i_hold;
`ifdef SHA_RC_CTRL_ABORT_EN
    logic                i_abort;
`endif
    logic                o_busy;
    logic                o_done;
    logic                o_rc_enable;
    logic [ADDR_WTH-1:0] o_rc_add;
    logic                o_load_init;
    logic                o_round_vld;
    logic [ADDR_WTH-1:0] o_round_idx;
    logic                o_msg_sel;
    logic                o_final_add;

    modport master (
        output i_start, i_hold,
`ifdef SHA_RC_CTRL_ABORT_EN
        output i_abort,
`endif
        input  o_busy, o_done, o_rc_enable, o_rc_add, o_load_init,
        input  o_round_vld, o_round_idx, o_msg_sel, o_final_add
    );

    modport slave (
        input  i_start, i_hold,
`ifdef SHA_RC_CTRL_ABORT_EN
        input  i_abort,
`endif
        output o_busy, o_done, o_rc_enable, o_rc_add, o_load_init,
        output o_round_vld, o_round_idx, o_msg_sel, o_final_add
    );
endinterface

// File: rtl/sha_round_cnt.sv
// Round index counter with synchronous clear, enable and terminal-count flag.
module sha_round_cnt #(
    parameter int ADDR_WTH = 6,
    parameter int LAST     = 63
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clr,
    input  logic                en,
    output logic [ADDR_WTH-1:0] cnt,
    output logic                last
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == ADDR_WTH'(LAST));

endmodule

// File: rtl/sha_round_ctrl.sv
// SHA-256 block compression sequencer: drives the K ROM one cycle ahead of the round datapath.
// Optional abort input enabled by defining SHA_RC_CTRL_ABORT_EN.
module sha_round_ctrl #(
    parameter int ADDR_WTH   = sha_ctrl_pkg::ADDR_WTH,
    parameter int NUM_ROUNDS = sha_ctrl_pkg::NUM_ROUNDS
) (
    input  logic             clk,
    input  logic             reset_n,
    sha_round_ctrl_if.slave  bus
);
    import sha_ctrl_pkg::*;

    ctrl_state_t         state;
    ctrl_state_t         state_nxt;
    logic [ADDR_WTH-1:0] round_cnt;
    logic                cnt_clr;
    logic                cnt_en;
    logic                cnt_last;
    logic                abort_req;

`ifdef SHA_RC_CTRL_ABORT_EN
    assign abort_req = bus.i_abort;
`else
    assign abort_req = 1'b0;
`endif

    sha_round_cnt #(
        .ADDR_WTH (ADDR_WTH),
        .LAST     (NUM_ROUNDS - 1)
    ) u_round_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .cnt     (round_cnt),
        .last    (cnt_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs decode from state, so an asynchronous reset forces them all low at once.
    always_comb begin
        state_nxt       = state;
        cnt_clr         = 1'b1;
        cnt_en          = 1'b0;
        bus.o_busy      = 1'b0;
        bus.o_done      = 1'b0;
        bus.o_rc_enable = 1'b0;
        bus.o_rc_add    = '0;
        bus.o_load_init = 1'b0;
        bus.o_round_vld = 1'b0;
        bus.o_round_idx = '0;
        bus.o_msg_sel   = 1'b0;
        bus.o_final_add = 1'b0;

        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    state_nxt = INIT;
                end
            end
            INIT: begin
                bus.o_busy      = 1'b1;
                bus.o_load_init = 1'b1;
                bus.o_rc_enable = 1'b1;
                state_nxt       = ROUND;
            end
            ROUND: begin
                bus.o_busy      = 1'b1;
                cnt_clr         = 1'b0;
                bus.o_round_idx = round_cnt;
                bus.o_msg_sel   = (round_cnt < ADDR_WTH'(MSG_WORDS));
                // The address never wraps to 0 as a live read; the last round parks it at 0 disabled.
                bus.o_rc_add    = cnt_last ? '0 : round_cnt + 1'b1;
                if (!bus.i_hold) begin
                    bus.o_round_vld = 1'b1;
                    if (cnt_last) begin
                        state_nxt = FINAL;
                    end else begin
                        bus.o_rc_enable = 1'b1;
                        cnt_en          = 1'b1;
                    end
                end
            end
            FINAL: begin
                bus.o_busy      = 1'b1;
                bus.o_final_add = 1'b1;
                state_nxt       = DONE;
            end
            DONE: begin
                bus.o_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (abort_req && (state inside {INIT, ROUND, FINAL})) begin
            state_nxt = IDLE;
        end
    end

endmodule

// File: tb/tb_sha_round_ctrl.sv
// Directed bench for sha_round_ctrl with a behavioural K ROM; abort test runs when SHA_RC_CTRL_ABORT_EN is defined.
module tb_sha_round_ctrl;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       load_init;
        logic       vld;
        logic [5:0] idx;
        logic       msg_sel;
        logic       final_add;
        logic       rc_en;
        logic [5:0] rc_add;
    } obs_t;

    typedef struct {
        int hold_start;
        int hold_len;
        int start_pulse;
        int start_held;
        int exp_fin;
        int exp_done;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic [31:0] rom_q;
    logic [31:0] k_tab [64];
    obs_t        obs;
    vec_t        vecs [6];
    int          checks;
    int          errors;

    sha_round_ctrl_if bus ();

    sha_round_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROM with enable: output holds while enable is low.
    always @(posedge clk) begin
        if (bus.o_rc_enable) begin
            rom_q <= k_tab[bus.o_rc_add];
        end
    end

    assign obs = {bus.o_busy, bus.o_done, bus.o_load_init, bus.o_round_vld, bus.o_round_idx,
                  bus.o_msg_sel, bus.o_final_add, bus.o_rc_enable, bus.o_rc_add};

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1 check_output("reset_state", 32'(obs), 32'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Runs one block from the start cycle (c=0) and checks every cycle against the timing model.
    task automatic apply_stimulus(input vec_t v);
        obs_t exp_o;
        obs_t mask;
        int   last_c;
        int   fin;
        int   idx;
        int   done_cyc;
        int   fin_cyc;
        int   done_cnt;
        bit   in_hold;
        fin      = 66 + v.hold_len;
        last_c   = 67 + v.hold_len + 2;
        done_cyc = -1;
        fin_cyc  = -1;
        done_cnt = 0;
        @(posedge clk);
        #1;
        bus.i_start = 1'b1;
        bus.i_hold  = 1'b0;
        for (int c = 1; c <= last_c; c++) begin
            @(posedge clk);
            #1;
            bus.i_start = (v.start_held != 0) || (c == v.start_pulse);
            bus.i_hold  = (c >= v.hold_start) && (c < v.hold_start + v.hold_len);
            @(negedge clk);
            exp_o = '0;
            mask  = '1;
            if (c == 1 || (v.start_held != 0 && c == fin + 3)) begin
                exp_o.busy      = 1'b1;
                exp_o.load_init = 1'b1;
                exp_o.rc_en     = 1'b1;
            end else if (c >= 2 && c < fin) begin
                in_hold = (v.hold_len > 0) && (c >= v.hold_start) && (c < v.hold_start + v.hold_len);
                if (in_hold) begin
                    idx = v.hold_start - 2;
                end else if (c >= v.hold_start + v.hold_len) begin
                    idx = c - 2 - v.hold_len;
                end else begin
                    idx = c - 2;
                end
                exp_o.busy = 1'b1;
                exp_o.idx  = 6'(idx);
                if (in_hold) begin
                    mask.rc_add  = '0;
                    mask.msg_sel = 1'b0;
                    if (idx == 20) check_output("k20_hold", rom_q, 32'h2de92c6f);
                end else begin
                    exp_o.vld     = 1'b1;
                    exp_o.msg_sel = (idx < 16);
                    exp_o.rc_en   = (idx != 63);
                    exp_o.rc_add  = (idx == 63) ? 6'd0 : 6'(idx + 1);
                    check_output($sformatf("rom_k c%0d", c), rom_q, k_tab[idx]);
                    if (idx == 0)  check_output("k_idx0", rom_q, 32'h428a2f98);
                    if (idx == 63) check_output("k_idx63", rom_q, 32'hc67178f2);
                end
            end else if (c == fin) begin
                exp_o.busy      = 1'b1;
                exp_o.final_add = 1'b1;
            end else if (c == fin + 1) begin
                exp_o.done = 1'b1;
            end
            check_output($sformatf("outputs c%0d", c), 32'(obs & mask), 32'(exp_o & mask));
            if (bus.o_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (bus.o_final_add && fin_cyc < 0) fin_cyc = c;
        end
        bus.i_start = 1'b0;
        bus.i_hold  = 1'b0;
        check_output("final_add_cycle", 32'(fin_cyc), 32'(v.exp_fin));
        check_output("done_cycle", 32'(done_cyc), 32'(v.exp_done));
        check_output("done_count", 32'(done_cnt), 32'd1);
    endtask

    initial begin
        k_tab = '{
            32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
            32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
            32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
            32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
            32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
            32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
            32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
            32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
        };
        // hold_start/hold_len in cycles after the start edge; round i runs in cycle i+2
        vecs[0] = '{hold_start: 0,  hold_len: 0, start_pulse: 0,  start_held: 0, exp_fin: 66, exp_done: 67};
        vecs[1] = '{hold_start: 22, hold_len: 3, start_pulse: 0,  start_held: 0, exp_fin: 69, exp_done: 70};
        vecs[2] = '{hold_start: 0,  hold_len: 0, start_pulse: 32, start_held: 0, exp_fin: 66, exp_done: 67};
        vecs[3] = '{hold_start: 0,  hold_len: 0, start_pulse: 0,  start_held: 1, exp_fin: 66, exp_done: 67};
        vecs[4] = '{hold_start: 65, hold_len: 1, start_pulse: 0,  start_held: 0, exp_fin: 67, exp_done: 68};
        vecs[5] = '{hold_start: 17, hold_len: 2, start_pulse: 0,  start_held: 0, exp_fin: 68, exp_done: 69};

        checks      = 0;
        errors      = 0;
        reset_n     = 1'b0;
        bus.i_start = 1'b0;
        bus.i_hold  = 1'b0;
`ifdef SHA_RC_CTRL_ABORT_EN
        bus.i_abort = 1'b0;
`endif
        #12 reset_n = 1'b1;
        apply_reset();

        for (int i = 0; i < 6; i++) begin
            $display("[TB] vector %0d", i);
            apply_stimulus(vecs[i]);
            apply_reset();
        end

        // Asynchronous reset in the middle of round 40, then a clean block.
        @(posedge clk);
        #1 bus.i_start = 1'b1;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        repeat (41) @(posedge clk);
        #2 check_output("idx_before_reset", 32'(bus.o_round_idx), 32'd40);
        reset_n = 1'b0;
        #1 check_output("reset_async", 32'(obs), 32'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        apply_stimulus(vecs[0]);
        apply_reset();

`ifdef SHA_RC_CTRL_ABORT_EN
        begin
            int seen;
            seen = 0;
            @(posedge clk);
            #1 bus.i_start = 1'b1;
            @(posedge clk);
            #1 bus.i_start = 1'b0;
            repeat (11) @(posedge clk);
            #1 bus.i_abort = 1'b1;
            #1 check_output("idx_at_abort", 32'(bus.o_round_idx), 32'd10);
            @(posedge clk);
            #1 bus.i_abort = 1'b0;
            #1 check_output("abort_outputs", 32'(obs), 32'h0);
            for (int c = 0; c < 70; c++) begin
                @(negedge clk);
                if (bus.o_done || bus.o_final_add) seen++;
            end
            check_output("abort_no_done", 32'(seen), 32'd0);
            apply_stimulus(vecs[0]);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha_round_ctrl.md
# sha_round_ctrl

Sequencer for one SHA-256 block compression. It issues round-constant ROM addresses 0..63 one cycle ahead of use, so the round datapath sees K[i] and its round index aligned with a single valid strobe. It also generates the working-variable load, message-select, final-add and done controls. It sits between the top-level hash FSM (start/done) and the round_constant ROM plus compression datapath.

## Interface
- ADDR_WTH, 6, ROM address width; round index width
- NUM_ROUNDS, 64, rounds per block; must equal 2**ADDR_WTH
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- i_start  in  1  request compression of one block; sampled only in IDLE
- i_hold  in  1  stall request; effective only in ROUND
- o_busy  out  1  high in INIT, ROUND, FINAL
- o_done  out  1  one-cycle pulse at block completion
- o_rc_enable  out  1  drives ROM enable
- o_rc_add  out  ADDR_WTH  drives ROM address
- o_load_init  out  1  one-cycle pulse: load a..h from H registers
- o_round_vld  out  1  datapath consumes K[o_round_idx] this cycle
- o_round_idx  out  ADDR_WTH  index of the round being executed
- o_msg_sel  out  1  1: W from message words (idx<16); 0: from schedule expansion
- o_final_add  out  1  one-cycle pulse: H += a..h

## Operation
- ROM contract: registered read, 1-cycle latency when enable=1; output holds when enable=0.
- States are IDLE, INIT, ROUND, FINAL, DONE.
- IDLE: wait for i_start=1, then go to INIT.
- INIT: o_load_init=1, o_rc_enable=1, o_rc_add=0. Go to ROUND.
- ROUND with i_hold=0:
  - o_round_vld=1, o_rc_enable=1.
  - o_rc_add = o_round_idx+1 while o_round_idx<63.
  - At o_round_idx=63 drive o_rc_add=0 and o_rc_enable=0, then go to FINAL.
  - Otherwise o_round_idx increments.
- ROUND with i_hold=1: o_round_vld=0, o_rc_enable=0, o_round_idx and o_rc_add frozen. ROM output therefore still holds K[o_round_idx].
- FINAL: o_final_add=1. Go to DONE.
- DONE: o_done=1, o_busy=0. Go to IDLE.
- o_msg_sel = (o_round_idx < 16), valid whenever o_round_vld=1. Driven 0 outside ROUND.
- i_start outside IDLE is ignored; it is not queued. i_start held high re-launches one cycle after DONE.
- i_hold outside ROUND is ignored. i_hold together with the round-63 cycle stalls at round 63.
- Counters are unsigned ADDR_WTH bits. o_rc_add never wraps to 0 as a read during a block.

## Timing
- Reset value of every output is 0. State resets to IDLE.
- Reset mid-block returns to IDLE immediately. No o_done, no o_final_add.
- i_start=1 sampled at edge T gives:
  - INIT in cycle T+1.
  - Rounds 0..63 in cycles T+2..T+65, with no holds.
  - FINAL at T+66.
  - o_done at T+67.
- Each hold cycle adds exactly one cycle to that latency.
- Earliest next start is sampled in the IDLE cycle T+68. Start-to-start spacing is 68 cycles.

## Configuration
- Macro SHA_RC_CTRL_ABORT_EN.
- Defined: adds input i_abort (1 bit).
  - i_abort=1 in INIT, ROUND or FINAL forces IDLE at the next edge.
  - o_final_add and o_done are not asserted for that block.
  - All outputs are 0 in the following cycle.
  - i_abort has priority over i_hold. It is ignored in IDLE and DONE.
- Undefined: the port is absent and blocks always run to completion.

## Structure
- Package sha_ctrl_pkg holds:
  - typedef enum for the state (IDLE, INIT, ROUND, FINAL, DONE)
  - NUM_ROUNDS=64
  - MSG_WORDS=16
  - ADDR_WTH=6
- Sub-module sha_round_cnt: ADDR_WTH counter with clear, enable and terminal-count flag. It is instantiated once and yields o_round_idx.
- The ROM stays external. The bench connects this block to round_constant and checks the K values.

## Test plan
- Reset then one start pulse, no hold:
  - o_load_init at T+1.
  - o_round_vld high T+2..T+65 with idx 0..63; ROM output 428a2f98 at idx 0 and c67178f2 at idx 63.
  - o_final_add at T+66, o_done at T+67.
- i_hold=1 for 3 cycles at idx 20: idx stays 20 and ROM output stays K[20]=2de92c6f. o_done moves to T+70.
- i_start pulsed at idx 30: no effect, single o_done at T+67. i_start held high: second INIT at T+69.
- o_msg_sel: 1 for idx 0..15, 0 for idx 16..63, 0 outside ROUND.
- reset_n low at idx 40: all outputs 0 asynchronously. After release, a new start runs a full 67-cycle block.
- With SHA_RC_CTRL_ABORT_EN, i_abort at idx 10: IDLE next cycle, no o_final_add, no o_done. A following start completes normally.
